// File: rtl/snes_sched_pkg.sv
// Shared definitions for the SNES controller frame scheduler: FSM encoding,
// idle-line value and the placement of the three line words inside a frame.
package snes_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } sched_state_t;

  localparam logic [31:0] IDLE_WORD_DEFAULT = 32'hFFFF_FFFF;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 3;
  localparam int FRAME_W   = WORD_W * NUM_WORDS;

  localparam int D0_LSB = 0;
  localparam int D1_LSB = 32;
  localparam int D2_LSB = 64;

  function automatic int word_lsb(input int idx);
    case (idx)
      0:       return D0_LSB;
      1:       return D1_LSB;
      default: return D2_LSB;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock frame FIFO with wrap-around pointers and a registered read port,
// so the popped head appears on rd_data the cycle after rd_en.
module sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [4:0]       level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [4:0]       count_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             wr_fire;
  logic             rd_fire;

  // A clear wins over both ports in the same cycle.
  assign wr_fire = wr_en & ~full & ~clr;
  assign rd_fire = rd_en & ~empty & ~clr;

  assign full    = (count_reg == 5'(DEPTH));
  assign empty   = (count_reg == 5'd0);
  assign level   = count_reg;
  assign rd_data = rd_data_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= 5'd0;
    end else begin
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {4'd0, wr_fire} - {4'd0, rd_fire};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_reg] <= wr_data;
    if (rd_fire) rd_data_reg <= mem[rd_ptr_reg];
  end

endmodule

// File: rtl/snes_frame_scheduler.sv
// Feeds queued controller frames to the 3-line shift-register controller, one
// frame per console latch, with latch synchronization and usage counters.
module snes_frame_scheduler
  import snes_sched_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lat_in,
  input  logic        enable,
  input  logic        flush,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [95:0] wr_data,
  output logic [31:0] data0,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic        lat_sync,
  output logic [4:0]  fifo_level,
  output logic [15:0] latch_count,
  output logic [15:0] underflow_count
);

  sched_state_t state_reg, state_next;

  logic               sync1_reg, sync2_reg, prev_reg;
  logic               fall;
  logic               pop;
  logic               count_fall;
  logic               underflow;
  logic               load_pending_reg;
  logic               hold_idle;
  logic [15:0]        latch_count_reg;
  logic [15:0]        underflow_count_reg;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FRAME_W-1:0] fifo_rd_data;
  logic [WORD_W-1:0]  word_reg [NUM_WORDS];

  assign fall = prev_reg & ~sync2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= lat_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // Dropping enable always returns to IDLE, whatever the current state.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    count_fall = 1'b0;
    underflow  = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  state_next = ST_PRIME;
        ST_PRIME: begin
          if (!fifo_empty && !flush) begin
            pop        = 1'b1;
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (fall) begin
            count_fall = 1'b1;
            if (fifo_empty || flush) underflow = 1'b1;
            else                     pop       = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= ST_IDLE;
      load_pending_reg    <= 1'b0;
      latch_count_reg     <= 16'd0;
      underflow_count_reg <= 16'd0;
    end else begin
      state_reg        <= state_next;
      load_pending_reg <= pop;
      if (count_fall) latch_count_reg     <= sat_inc16(latch_count_reg);
      if (underflow)  underflow_count_reg <= sat_inc16(underflow_count_reg);
    end
  end

  assign hold_idle = !enable || (state_reg == ST_IDLE);

  // The popped head lands on fifo_rd_data one cycle after the pop.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    always_ff @(posedge clk) begin
      if (rst || hold_idle) word_reg[gi] <= IDLE_WORD;
      else if (load_pending_reg) word_reg[gi] <= fifo_rd_data[word_lsb(gi) +: WORD_W];
    end
  end

  sync_fifo #(
    .WIDTH(FRAME_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .wr_en  (wr_valid),
    .wr_data(wr_data),
    .rd_en  (pop),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign wr_ready        = ~fifo_full;
  assign data0           = word_reg[0];
  assign data1           = word_reg[1];
  assign data2           = word_reg[2];
  assign lat_sync        = sync2_reg;
  assign latch_count     = latch_count_reg;
  assign underflow_count = underflow_count_reg;

endmodule
